bcd_counter_4d: RTL and testbench
=================================

// Module: bcd_counter_4d
// PURPOSE
// - 4-digit BCD up-counter with segment encoding; directly upstream of the 4-digit display multiplexer.
// - Produces four active-low 7-seg patterns (seg3..seg0) and a dp vector, wired 1:1 to the mux digit/dp inputs.
// - Count source: debounced push-button pulse (inc) and/or an internal auto-increment prescaler.
// PARAMETERS
// - TICK_DIV  50_000_000  clk cycles per auto-increment step; legal range >= 2.
// - LZB       1           1 = leading-zero blanking on; 0 = all digits always lit.
// - DP_MASK   4'b0000     constant dp_out value (bit i = decimal point of digit i).
// PORTS
// - clk       in   1   system clock, rising edge.
// - reset     in   1   asynchronous, active-high.
// - inc       in   1   asynchronous level from a debounced button; each rising edge = one step.
// - clr       in   1   synchronous clear, active-high.
// - auto_en   in   1   1 = prescaler steps the count every TICK_DIV cycles.
// - seg3..0   out  8   active-low pattern per digit: [7]=dp (always 1 here), [6:0]={g,f,e,d,c,b,a}.
// - dp_out    out  4   active-high dp request per digit; equals DP_MASK.
// - bcd       out  16  registered count {d3,d2,d1,d0}, 4 bits per digit.
// - ovf       out  1   one-cycle pulse on 9999->0000 wrap.
// BEHAVIOUR
// - Reset values: bcd=16'h0000, ovf=0, prescaler=0, sync/edge flops=0.
//   seg0=8'hC0; seg3..1 = 8'hFF when LZB=1, else 8'hC0.
// - inc path: 2-flop synchroniser, then rising-edge detect giving a 1-cycle inc_pulse.
//   If inc rises before edge E0, bcd updates at edge E2.
// - Prescaler: counts 0..TICK_DIV-1 while auto_en=1; tick=1 in the cycle where count==TICK_DIV-1, then wraps to 0.
//   auto_en=0 holds the prescaler at 0.
// - step = inc_pulse | tick. A coincident inc_pulse and tick advance the count by exactly 1.
// - Priority per cycle: clr > step > hold.
//   clr zeroes bcd and the prescaler; ovf stays 0 that cycle, even if a step coincides.
// - Increment: d0+1; digit i wraps 9->0 and carries into digit i+1. Carries ripple combinationally within one cycle.
// - Wrap: 9999 + step -> 0000 at edge E; ovf=1 for the single cycle after E.
// - Digit values >9 are unreachable; the decoder maps them to blank (8'hFF).
// - Encoding (dp bit included):
//   0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
// - seg outputs are registered from bcd: seg changes 1 cycle after bcd.
// - LZB=1: digit i (i>=1) is blanked (8'hFF) when it and every higher digit are 0. seg0 is never blanked.
// - dp_out = DP_MASK, constant. The downstream mux overrides seg[7] from dp_out.
// - reset asserted mid-count returns all state to reset values immediately, with no glitch-dependent carry.
// STRUCTURE
// - Shared include sseg_defs.vh: SSEG_0..SSEG_9 and SSEG_BLANK (8'hFF) constants, plus segment bit-order note.
//   The display-path blocks share this file.
// - Sub-module bcd_to_sseg: combinational 4-bit -> 8-bit active-low decoder, instantiated 4x.
// - Synchroniser, edge detector, prescaler, BCD digit chain and output registers live in this module.
// TESTING (bench uses TICK_DIV=8)
// - Reset release -> bcd=0000, seg0=C0, seg3..1=FF (LZB=1), ovf=0, dp_out=DP_MASK.
// - Three inc pulses, each 5 cycles high -> bcd=0003, seg0=B0; inc held high for 20 cycles -> exactly one step.
// - Load 0099 via steps, then one inc -> bcd=0100 at E2, seg2=F9, seg1=C0, seg0=C0, seg3=FF.
// - Count to 9999, then one inc -> bcd=0000 and ovf high for exactly 1 cycle.
// - auto_en=1 for 80 cycles -> 10 steps (bcd=0010); tick coincident with inc_pulse -> +1 only.
// - clr asserted in the same cycle as step -> bcd=0000, ovf=0; reset asserted mid-run -> all outputs at reset values.

Source files
------------

// File: rtl/bcd_counter_4d_pkg.sv
// Shared display-path definitions: seven-segment codes and BCD increment helper.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
package bcd_counter_4d_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment bit order, active low: [7]=dp, [6:0]={g,f,e,d,c,b,a}.
   // The dp bit is held at 1 here; the downstream mux drives the real dp.
   localparam logic [7:0] SSEG_0     = 8'hC0;
   localparam logic [7:0] SSEG_1     = 8'hF9;
   localparam logic [7:0] SSEG_2     = 8'hA4;
   localparam logic [7:0] SSEG_3     = 8'hB0;
   localparam logic [7:0] SSEG_4     = 8'h99;
   localparam logic [7:0] SSEG_5     = 8'h92;
   localparam logic [7:0] SSEG_6     = 8'h82;
   localparam logic [7:0] SSEG_7     = 8'hF8;
   localparam logic [7:0] SSEG_8     = 8'h80;
   localparam logic [7:0] SSEG_9     = 8'h90;
   localparam logic [7:0] SSEG_BLANK = 8'hFF;

   typedef logic [3:0] digit_t;

   // Result of one BCD increment: new value plus the carry out of the top digit.
   typedef struct packed {
      logic [15:0] value;
      logic        wrap;
   } bcd_step_t;

   // Adds one to a packed 4-digit BCD value; the carry ripples through all
   // digits in one evaluation. A digit at 9 (or an unreachable >9 value)
   // rolls to 0 and passes the carry up.
   function automatic bcd_step_t bcd_increment(input logic [15:0] cur);
      bcd_step_t res;
      logic      carry;
      carry     = 1'b1;
      res.value = cur;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (cur[i*4 +: 4] >= 4'd9) begin
               res.value[i*4 +: 4] = 4'd0;
            end else begin
               res.value[i*4 +: 4] = cur[i*4 +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      res.wrap = carry;
      return res;
   endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// BCD digit to active-low seven-segment pattern decoder (dp bit held off).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module bcd_to_sseg
   import bcd_counter_4d_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   // Table lookup; codes above 9 cannot occur in the counter and show blank.
   always_comb begin
      seg = SSEG_BLANK;
      case (digit)
         4'd0:    seg = SSEG_0;
         4'd1:    seg = SSEG_1;
         4'd2:    seg = SSEG_2;
         4'd3:    seg = SSEG_3;
         4'd4:    seg = SSEG_4;
         4'd5:    seg = SSEG_5;
         4'd6:    seg = SSEG_6;
         4'd7:    seg = SSEG_7;
         4'd8:    seg = SSEG_8;
         4'd9:    seg = SSEG_9;
         default: seg = SSEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_counter_4d.sv
// 4-digit BCD up-counter with registered seven-segment outputs and leading-zero blanking.
// Latency: inc rise to bcd update 2 edges after first sample; seg follows bcd by 1 cycle.
// Backpressure: none; every step is taken, coincident inc/tick count once, clr wins.
module bcd_counter_4d
   import bcd_counter_4d_pkg::*;
#(
   parameter int         TICK_DIV = 50_000_000,
   parameter bit         LZB      = 1'b1,
   parameter logic [3:0] DP_MASK  = 4'b0000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        clr,
   input  logic        auto_en,
   output logic [7:0]  seg3,
   output logic [7:0]  seg2,
   output logic [7:0]  seg1,
   output logic [7:0]  seg0,
   output logic [3:0]  dp_out,
   output logic [15:0] bcd,
   output logic        ovf
);

   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  TICK_LAST  = PW'(TICK_DIV - 1);
   // Upper digits come out of reset blank when blanking is on (count is 0000).
   localparam logic [7:0]     SEG_HI_RST = LZB ? SSEG_BLANK : SSEG_0;

   logic          inc_meta;
   logic          inc_sync;
   logic          inc_prev;
   logic          inc_pulse;
   logic [PW-1:0] presc;
   logic          tick;
   logic          step;
   bcd_step_t     nxt;
   logic [7:0]    dec [NUM_DIGITS];
   logic [3:0]    blank;

   assign dp_out = DP_MASK;

   // Two-flop synchroniser for the asynchronous button level, plus a delay flop for edge detect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_meta <= 1'b0;
         inc_sync <= 1'b0;
         inc_prev <= 1'b0;
      end else begin
         inc_meta <= inc;
         inc_sync <= inc_meta;
         inc_prev <= inc_sync;
      end
   end

   // One-cycle pulse on each synchronised rising edge; a held button gives one step.
   assign inc_pulse = inc_sync & ~inc_prev;

   // Auto-increment prescaler: free-runs 0..TICK_DIV-1 only while enabled, parked at 0 otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (clr || !auto_en) begin
         presc <= '0;
      end else if (presc == TICK_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   assign tick = auto_en & (presc == TICK_LAST);

   // OR-ing the two sources means a coincident button pulse and tick advance by one only.
   assign step = inc_pulse | tick;

   // Next count with the full carry chain resolved in this cycle.
   always_comb begin
      nxt = bcd_increment(bcd);
   end

   // Count register and wrap flag: clear beats step, and a clear never reports a wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd <= 16'h0000;
         ovf <= 1'b0;
      end else if (clr) begin
         bcd <= 16'h0000;
         ovf <= 1'b0;
      end else if (step) begin
         bcd <= nxt.value;
         ovf <= nxt.wrap;
      end else begin
         ovf <= 1'b0;
      end
   end

   // One decoder per digit, fed straight from the registered count.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      bcd_to_sseg u_dec (
         .digit (bcd[g*4 +: 4]),
         .seg   (dec[g])
      );
   end

   // Leading-zero mask: a digit blanks only if it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      blank    = 4'b0000;
      blank[3] = LZB && (bcd[15:12] == 4'd0);
      blank[2] = blank[3] && (bcd[11:8] == 4'd0);
      blank[1] = blank[2] && (bcd[7:4] == 4'd0);
      blank[0] = 1'b0;
   end

   // Registered segment outputs so the display mux sees clean, glitch-free patterns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg3 <= SEG_HI_RST;
         seg2 <= SEG_HI_RST;
         seg1 <= SEG_HI_RST;
         seg0 <= SSEG_0;
      end else begin
         seg3 <= blank[3] ? SSEG_BLANK : dec[3];
         seg2 <= blank[2] ? SSEG_BLANK : dec[2];
         seg1 <= blank[1] ? SSEG_BLANK : dec[1];
         seg0 <= dec[0];
      end
   end

endmodule

// File: tb/tb_bcd_counter_4d.sv
// Self-checking bench for bcd_counter_4d: vector table, hand sequences and random run against an integer model.
// Latency: model tracks the 2-edge inc path and 1-cycle seg lag.
// Backpressure: not applicable.
module tb_bcd_counter_4d;

   localparam int         TB_TICK = 8;
   localparam bit         TB_LZB  = 1'b1;
   localparam logic [3:0] TB_DP   = 4'b0101;

   logic        clk;
   logic        reset;
   logic        inc;
   logic        clr;
   logic        auto_en;
   logic [7:0]  seg3;
   logic [7:0]  seg2;
   logic [7:0]  seg1;
   logic [7:0]  seg0;
   logic [3:0]  dp_out;
   logic [15:0] bcd;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model state: plain integers.
   int       m_count;
   int       m_seg_count;
   int       m_presc;
   bit       m_ovf;
   bit [2:0] m_hist;
   bit       m_pulse;
   bit       m_tick;

   bcd_counter_4d #(
      .TICK_DIV (TB_TICK),
      .LZB      (TB_LZB),
      .DP_MASK  (TB_DP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc),
      .clr     (clr),
      .auto_en (auto_en),
      .seg3    (seg3),
      .seg2    (seg2),
      .seg1    (seg1),
      .seg0    (seg0),
      .dp_out  (dp_out),
      .bcd     (bcd),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Display code for a decimal digit.
   function automatic logic [7:0] enc(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   // Expected pattern of display position k for the decimal number n.
   function automatic logic [7:0] exp_seg(input int n, input int k);
      if (TB_LZB && k > 0 && n < pow10(k)) return 8'hFF;
      return enc((n / pow10(k)) % 10);
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   // Behavioural model: an inc level rising before edge E0 counts at E2; ticks every TB_TICK enabled cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_count     = 0;
         m_seg_count = 0;
         m_presc     = 0;
         m_ovf       = 1'b0;
         m_hist      = 3'b000;
      end else begin
         m_seg_count = m_count;
         m_pulse     = m_hist[1] && !m_hist[2];
         m_tick      = auto_en && (m_presc == TB_TICK - 1);
         m_presc     = (clr || !auto_en) ? 0 : (m_presc + 1) % TB_TICK;
         if (clr) begin
            m_count = 0;
            m_ovf   = 1'b0;
         end else if (m_pulse || m_tick) begin
            m_ovf   = (m_count == 9999);
            m_count = (m_count + 1) % 10000;
         end else begin
            m_ovf = 1'b0;
         end
         m_hist = {m_hist[1:0], inc};
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      logic [52:0] act;
      logic [52:0] exp;
      act = {bcd, seg3, seg2, seg1, seg0, ovf, dp_out};
      exp = {to_bcd(m_count), exp_seg(m_seg_count, 3), exp_seg(m_seg_count, 2),
             exp_seg(m_seg_count, 1), exp_seg(m_seg_count, 0), m_ovf, TB_DP};
      check(name, 64'(act), 64'(exp));
   endtask

   // Advance n cycles; outputs are sampled at the falling edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         if (chk_en) check_model("model");
      end
   endtask

   task automatic pulse(input int hi, input int lo);
      inc = 1'b1;
      cyc(hi);
      inc = 1'b0;
      cyc(lo);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask

   typedef struct {
      int          npulse;
      int          hi;
      int          lo;
      int          auto_cyc;
      logic [15:0] exp_bcd;
      logic [7:0]  exp_seg0;
      logic [7:0]  exp_seg1;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ovf_cnt;

      vecs[0] = '{3,  5,  5, 0,  16'h0003, 8'hB0, 8'hFF};
      vecs[1] = '{1,  20, 5, 0,  16'h0001, 8'hF9, 8'hFF};
      vecs[2] = '{0,  0,  0, 80, 16'h0010, 8'hC0, 8'hF9};
      vecs[3] = '{7,  1,  1, 0,  16'h0007, 8'hF8, 8'hFF};
      vecs[4] = '{12, 2,  3, 0,  16'h0012, 8'hA4, 8'hF9};
      vecs[5] = '{25, 1,  2, 0,  16'h0025, 8'h92, 8'hA4};
      vecs[6] = '{0,  0,  0, 20, 16'h0002, 8'hA4, 8'hFF};

      inc     = 1'b0;
      clr     = 1'b0;
      auto_en = 1'b0;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_bcd", 64'(bcd), 64'h0000);
      check("rst_seg0", 64'(seg0), 64'hC0);
      check("rst_seg321", 64'({seg3, seg2, seg1}), 64'hFFFFFF);
      check("rst_ovf", 64'(ovf), 64'h0);
      check("rst_dp", 64'(dp_out), 64'(TB_DP));
      chk_en = 1'b1;

      // Table-driven vectors, each from a cleared count.
      for (int v = 0; v < 7; v++) begin
         do_clr();
         for (int p = 0; p < vecs[v].npulse; p++) pulse(vecs[v].hi, vecs[v].lo);
         if (vecs[v].auto_cyc > 0) begin
            auto_en = 1'b1;
            cyc(vecs[v].auto_cyc);
            auto_en = 1'b0;
         end
         cyc(4);
         check($sformatf("vec%0d_bcd", v), 64'(bcd), 64'(vecs[v].exp_bcd));
         check($sformatf("vec%0d_seg0", v), 64'(seg0), 64'(vecs[v].exp_seg0));
         check($sformatf("vec%0d_seg1", v), 64'(seg1), 64'(vecs[v].exp_seg1));
      end

      // 0099 -> 0100 with exact edge timing.
      do_clr();
      repeat (99) pulse(1, 1);
      cyc(4);
      check("load_0099", 64'(bcd), 64'h0099);
      inc = 1'b1;
      cyc(1);
      check("e0_hold", 64'(bcd), 64'h0099);
      cyc(1);
      check("e1_hold", 64'(bcd), 64'h0099);
      cyc(1);
      check("e2_bcd", 64'(bcd), 64'h0100);
      check("e2_seg_lag", 64'(seg0), 64'h90);
      cyc(1);
      check("e3_segs", 64'({seg3, seg2, seg1, seg0}), 64'hFFF9C0C0);
      inc = 1'b0;
      cyc(2);

      // 9999 -> 0000 wrap with single-cycle ovf.
      chk_en = 1'b0;
      do_clr();
      repeat (9999) pulse(1, 1);
      cyc(4);
      chk_en = 1'b1;
      check("load_9999", 64'(bcd), 64'h9999);
      check("segs_9999", 64'({seg3, seg2, seg1, seg0}), 64'h90909090);
      inc     = 1'b1;
      ovf_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (ovf) ovf_cnt++;
      end
      inc = 1'b0;
      check("wrap_bcd", 64'(bcd), 64'h0000);
      check("wrap_ovf_cycles", 64'(ovf_cnt), 64'd1);
      check("wrap_segs", 64'({seg3, seg2, seg1, seg0}), 64'hFFFFFFC0);

      // Tick (8th enabled edge) coincident with inc_pulse: count moves by one.
      do_clr();
      auto_en = 1'b1;
      cyc(5);
      inc = 1'b1;
      cyc(3);
      auto_en = 1'b0;
      cyc(2);
      inc = 1'b0;
      cyc(3);
      check("coincide_bcd", 64'(bcd), 64'h0001);

      // clr in the same cycle as a step.
      do_clr();
      repeat (5) pulse(1, 1);
      cyc(3);
      check("pre_clr_bcd", 64'(bcd), 64'h0005);
      inc = 1'b1;
      cyc(2);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("clr_step_bcd", 64'(bcd), 64'h0000);
      check("clr_step_ovf", 64'(ovf), 64'h0);
      cyc(3);
      inc = 1'b0;
      cyc(2);
      check("clr_step_after", 64'(bcd), 64'h0000);

      // Randomised run checked every cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) inc = ~inc;
         clr = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
         cyc(1);
      end
      inc     = 1'b0;
      clr     = 1'b0;
      auto_en = 1'b0;
      cyc(4);

      // Asynchronous reset in the middle of a running count.
      do_clr();
      repeat (12) pulse(1, 1);
      cyc(3);
      check("pre_reset_bcd", 64'(bcd), 64'h0012);
      auto_en = 1'b1;
      cyc(3);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_bcd", 64'(bcd), 64'h0000);
      check("midrst_ovf", 64'(ovf), 64'h0);
      check("midrst_segs", 64'({seg3, seg2, seg1, seg0}), 64'hFFFFFFC0);
      check("midrst_dp", 64'(dp_out), 64'(TB_DP));
      @(negedge clk);
      reset   = 1'b0;
      auto_en = 1'b0;
      cyc(4);
      check("post_rst_bcd", 64'(bcd), 64'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
